// File: rtl/spram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : spram_bus_bridge
//  Description : 32-bit valid/ready request/response bus onto a 16K x 16
//                single-port RAM, one 16-bit half per clock.
//  Revision    : 1.0 - initial release
// ============================================================================

module spram_bus_bridge #(
    localparam int ADDRW = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [3:0]       req_be,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic [13:0]      spram_addr,
    output logic [3:0]       spram_we,
    output logic [15:0]      spram_din,
    input  logic [15:0]      spram_dout
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LO   = 3'd1;
    localparam logic [2:0] c_HI   = 3'd2;
    localparam logic [2:0] c_CAP  = 3'd3;
    localparam logic [2:0] c_RESP = 3'd4;

    logic [2:0]       r_state;
    logic             r_live;
    logic             r_we;
    logic [3:0]       r_be;
    logic [ADDRW-1:0] r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             w_accept;

    // r_live keeps req_ready low while reset is held, even though the state is IDLE.
    assign req_ready = (r_state == c_IDLE) && r_live;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == c_RESP);
    assign rsp_rdata = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_live  <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_be    <= req_be;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= c_LO;
                    end
                end
                c_LO: r_state <= c_HI;
                c_HI: begin
                    if (r_we) begin
                        r_rdata <= 32'd0;
                        r_state <= c_RESP;
                    end else begin
                        // Low half addressed in LO is on spram_dout now.
                        r_rdata[15:0] <= spram_dout;
                        r_state       <= c_CAP;
                    end
                end
                c_CAP: begin
                    r_rdata[31:16] <= spram_dout;
                    r_state        <= c_RESP;
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        spram_addr = 14'd0;
        spram_din  = 16'd0;
        spram_we   = 4'b0000;
        case (r_state)
            c_LO: begin
                spram_addr = {r_addr, 1'b0};
                spram_din  = r_wdata[15:0];
                spram_we   = r_we ? {r_be[1], r_be[1], r_be[0], r_be[0]} : 4'b0000;
            end
            c_HI: begin
                spram_addr = {r_addr, 1'b1};
                spram_din  = r_wdata[31:16];
                spram_we   = r_we ? {r_be[3], r_be[3], r_be[2], r_be[2]} : 4'b0000;
            end
            default: begin
                spram_addr = 14'd0;
                spram_din  = 16'd0;
                spram_we   = 4'b0000;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_spram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spram_bus_bridge
//  Description : Directed bench for spram_bus_bridge with a nibble-masked
//                16K x 16 SPRAM model (registered read port).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_spram_bus_bridge;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [13:0] spram_addr;
    logic [3:0]  spram_we;
    logic [15:0] spram_din;
    logic [15:0] spram_dout;

    logic [15:0] mem [0:16383];

    int n_vec = 0;
    int n_bad = 0;

    spram_bus_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .spram_addr (spram_addr),
        .spram_we   (spram_we),
        .spram_din  (spram_din),
        .spram_dout (spram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (spram_we[k]) mem[spram_addr][4*k +: 4] <= spram_din[4*k +: 4];
        end
        spram_dout <= mem[spram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [12:0] a, input logic [3:0] be,
                             input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
    endtask

    // Scramble request inputs after accept so stale bus values cannot mask capture bugs.
    task automatic drop_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 13'h1555;
        req_be    = 4'b1010;
        req_wdata = 32'h5A5A_A5A5;
    endtask

    task automatic wr(input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
        chk("wr_ready", req_ready, 1);
        drive_req(1'b1, a, be, d);
        tick();
        drop_req();
        chk("wr_lo_addr", spram_addr, {a, 1'b0});
        chk("wr_lo_we", spram_we, {be[1], be[1], be[0], be[0]});
        chk("wr_lo_din", spram_din, d[15:0]);
        chk("wr_lo_busy", req_ready, 0);
        tick();
        chk("wr_hi_addr", spram_addr, {a, 1'b1});
        chk("wr_hi_we", spram_we, {be[3], be[3], be[2], be[2]});
        chk("wr_hi_din", spram_din, d[31:16]);
        chk("wr_hi_novalid", rsp_valid, 0);
        tick();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_rsp_we", spram_we, 0);
        tick();
        chk("wr_done_valid", rsp_valid, 0);
    endtask

    task automatic rd(input logic [12:0] a, input logic [31:0] exp);
        chk("rd_ready", req_ready, 1);
        drive_req(1'b0, a, 4'b1111, 32'hFFFF_FFFF);
        tick();
        drop_req();
        chk("rd_lo_addr", spram_addr, {a, 1'b0});
        chk("rd_lo_we", spram_we, 0);
        tick();
        chk("rd_hi_addr", spram_addr, {a, 1'b1});
        chk("rd_hi_we", spram_we, 0);
        tick();
        chk("rd_cap_novalid", rsp_valid, 0);
        chk("rd_cap_addr", spram_addr, 0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, exp);
        tick();
        chk("rd_done_valid", rsp_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drop_req();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_spram_we", spram_we, 0);
        chk("rst_spram_addr", spram_addr, 0);
        chk("rst_rdata", rsp_rdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rel_not_ready_yet", req_ready, 0);
        tick();
        chk("rel_ready", req_ready, 1);

        // Full write then read, cell contents checked directly.
        wr(13'd5, 4'b1111, 32'hDEAD_BEEF);
        chk("mem10", mem[10], 16'hBEEF);
        chk("mem11", mem[11], 16'hDEAD);
        rd(13'd5, 32'hDEAD_BEEF);

        // Byte-masked write: only byte 2 changes.
        wr(13'd20, 4'b1111, 32'h1122_3344);
        wr(13'd20, 4'b0100, 32'hAABB_CCDD);
        rd(13'd20, 32'h11BB_3344);

        // Zero byte enables still run both phases but change nothing.
        wr(13'd30, 4'b1111, 32'h5566_7788);
        wr(13'd30, 4'b0000, 32'hFFFF_FFFF);
        rd(13'd30, 32'h5566_7788);

        // Top of address range.
        wr(13'd8191, 4'b1111, 32'hA5A5_5A5A);
        chk("mem16382", mem[16382], 16'h5A5A);
        chk("mem16383", mem[16383], 16'hA5A5);
        rd(13'd8191, 32'hA5A5_5A5A);

        // Backpressure with an intruding write request that must be ignored.
        wr(13'd100, 4'b1111, 32'h1234_5678);
        wr(13'd200, 4'b1111, 32'hCAFE_F00D);
        rsp_ready = 1'b0;
        drive_req(1'b0, 13'd100, 4'b0000, 32'd0);
        tick();
        drive_req(1'b1, 13'd200, 4'b1111, 32'h0BAD_0BAD);
        tick();
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 32'h1234_5678);
            chk("bp_not_ready", req_ready, 0);
            chk("bp_no_write", spram_we, 0);
            tick();
        end
        chk("bp_still_valid", rsp_valid, 1);
        drop_req();
        rsp_ready = 1'b1;
        tick();
        chk("bp_released_valid", rsp_valid, 0);
        chk("bp_released_ready", req_ready, 1);
        rd(13'd200, 32'hCAFE_F00D);

        // Reset during the HI phase of a write.
        wr(13'd40, 4'b1111, 32'h0102_0304);
        drive_req(1'b1, 13'd40, 4'b1111, 32'hAAAA_BBBB);
        tick();
        drop_req();
        tick();
        chk("mid_hi_we", spram_we, 4'b1111);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", spram_we, 0);
        chk("mid_rst_addr", spram_addr, 0);
        chk("mid_rst_din", spram_din, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        tick();
        chk("mid_rst_hold_valid", rsp_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", req_ready, 1);
        chk("mid_rel_valid", rsp_valid, 0);
        rd(13'd40, 32'h0102_BBBB);

        // Back-to-back alternating traffic; task timing pins the 4/5-clock spacing.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = 32'h1000_0001 * (i + 3) ^ 32'h0F0F_0F0F;
            wr(13'd50 + 13'(i), 4'b1111, d);
            rd(13'd50 + 13'(i), d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spram_bus_bridge.md
SPRAM_BUS_BRIDGE -- requirements
Module: spram_bus_bridge

Interface
REQ-001 SHALL have localparam ADDRW, fixed at 13: 32-bit word address width, covering 8K words, i.e. 16K x 16 SPRAM.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: request present.
REQ-005 SHALL have port req_ready, output, 1 bit: bridge can accept a request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port req_be, input, 4 bits: byte enables; bit i enables byte i of req_wdata.
REQ-008 SHALL have port req_addr, input, ADDRW bits: 32-bit word address.
REQ-009 SHALL have port req_wdata, input, 32 bits: write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response present; asserted for reads and writes.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: read data; 0 for write responses.
REQ-013 SHALL have port spram_addr, output, 14 bits: to the SPRAM address port.
REQ-014 SHALL have port spram_we, output, 4 bits: SPRAM nibble write mask.
REQ-015 SHALL have port spram_din, output, 16 bits: SPRAM write data.
REQ-016 SHALL have port spram_dout, input, 16 bits: SPRAM read data, valid the cycle after the address edge.

Function
REQ-017 SHALL implement FSM states IDLE, LO, HI, CAP, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; handshake = req_valid & req_ready; on handshake, capture we/be/addr/wdata into registers and go IDLE->LO.
REQ-019 SHALL drive spram_* only from registered state and request registers, with no combinational path from req_* inputs.
REQ-020 SHALL, in LO, drive spram_addr={addr,1'b0} and spram_din=wdata[15:0]; spram_we={be[1],be[1],be[0],be[0]} if write, else 4'b0000.
REQ-021 SHALL, in HI, drive spram_addr={addr,1'b1} and spram_din=wdata[31:16]; spram_we={be[3],be[3],be[2],be[2]} if write, else 0.
REQ-022 SHALL, in all states other than LO and HI, hold spram_we=0 and spram_addr/spram_din at 0.
REQ-023 SHALL make transitions: LO->HI unconditionally; HI->CAP for reads, HI->RESP for writes; CAP->RESP.
REQ-024 SHALL, for reads, load rdata[15:0] from spram_dout on the HI->CAP edge and rdata[31:16] on the CAP->RESP edge.
REQ-025 SHALL, for writes, clear rdata to 0 on the HI->RESP edge.
REQ-026 SHALL hold rsp_valid=1 exactly in RESP, with rsp_rdata stable while rsp_valid=1 and rsp_ready=0.
REQ-027 SHALL make transitions RESP->IDLE when rsp_ready=1, otherwise stay in RESP (unbounded backpressure).
REQ-028 SHALL give latency from the accept edge to rsp_valid rising: 2 clocks for writes, 3 clocks for reads.
REQ-029 SHALL give a minimum request-to-request spacing of 4 clocks (write) and 5 clocks (read) with rsp_ready held high.
REQ-030 SHALL still execute both phases for req_be=0000 writes (spram_we=0 throughout) and respond normally.
REQ-031 SHALL ignore req_be for reads.
REQ-032 SHALL use the full ADDRW range with no wrap logic: address 8191 maps to SPRAM 16382/16383.
REQ-033 SHALL ignore req_valid while not in IDLE, and SHALL NOT change captured registers.
REQ-034 SHALL allow a new request to be accepted in the cycle following the RESP handshake, with no combinational req_ready from rsp_ready.

Reset
REQ-035 SHALL, on rst_n=0 (asynchronous), force state to IDLE and set all request registers and rdata to 0.
REQ-036 SHALL, during reset, drive req_ready=0, rsp_valid=0, spram_we=0, spram_addr=0 and spram_din=0 immediately.
REQ-037 SHALL, after rst_n deassertion, assert req_ready=1 from the first clock.
REQ-038 SHALL abort a transaction on reset mid-transaction with no response; a write interrupted after LO leaves its low half written and its high half unwritten.

Verification
REQ-039 SHALL cover full write then read: write addr=5, be=1111, wdata=0xDEADBEEF, then read addr=5 -> rsp_rdata=0xDEADBEEF after 3 clocks; SPRAM cells 10=0xBEEF and 11=0xDEAD.
REQ-040 SHALL cover a byte-masked write: preload 0x11223344, write be=0100, wdata=0xAABBCCDD -> HI phase spram_we=0011, read-back 0x11BB3344.
REQ-041 SHALL cover backpressure: read with rsp_ready=0 for 6 clocks -> rsp_valid held, rsp_rdata stable, req_ready=0 throughout, with a second req_valid ignored.
REQ-042 SHALL cover the top address: write/read addr=8191 -> spram_addr 16382 then 16383; data round-trips.
REQ-043 SHALL cover reset mid-op: rst_n low during HI of a write -> spram_we=0 in the same cycle, no rsp_valid; req_ready=1 one clock after release.
REQ-044 SHALL cover back-to-back traffic: 8 alternating writes/reads with rsp_ready=1 -> each read returns the last written value, with spacing of 4/5 clocks.
